mod_ram_ctrl: RTL and testbench

//   Parametrised dual-port (instruction/data) RAM controller; next generation of the CPU-side RAM.

---
 rtl/mod_ram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mod_ram_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mod_ram_ctrl.sv
// Instruction/data RAM controller with byte-lane writes, registered reads,
// out-of-range flags, write-first I/D collision and a post-reset clear pass.
module mod_ram_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH_LOG2 = 11,
    parameter int          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter bit          CLEAR_INIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                ie,
    input  logic [ADDR_W-1:0]   iaddr,
    output logic [DATA_W-1:0]   iout,
    output logic                ivalid,
    output logic                ierr,
    input  logic                de,
    input  logic                drw,
    input  logic [DATA_W/8-1:0] dbe,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                dvalid,
    output logic                derr
);

    localparam int NB    = DATA_W / 8;
    localparam int AB    = $clog2(NB);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    // Byte span of the array, one bit wider than the address so it
    // cannot overflow when the array fills the whole address space.
    localparam logic [ADDR_W:0] SPAN =
        (ADDR_W + 1)'(1) << (DEPTH_LOG2 + AB);

    localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  init_we;

    logic                  ivalid_q, ivalid_d;
    logic                  ierr_q, ierr_d;
    logic [DATA_W-1:0]     iout_q, iout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  derr_q, derr_d;
    logic [DATA_W-1:0]     dout_q, dout_d;

    logic [ADDR_W-1:0]     i_off, d_off;
    logic                  i_in, d_in;
    logic [DEPTH_LOG2-1:0] i_idx, d_idx;
    logic                  i_acc, d_acc, d_wr, i_hit;
    logic [DATA_W-1:0]     wmerge;

    // Address decode: offset from base, range test and word index.
    always_comb begin
        i_off = iaddr - BASE_ADDR;
        d_off = daddr - BASE_ADDR;
        i_in  = (iaddr >= BASE_ADDR) && ({1'b0, i_off} < SPAN);
        d_in  = (daddr >= BASE_ADDR) && ({1'b0, d_off} < SPAN);
        i_idx = i_off[AB +: DEPTH_LOG2];
        d_idx = d_off[AB +: DEPTH_LOG2];
        i_acc = ready_q & ie;
        d_acc = ready_q & de;
        d_wr  = d_acc & drw & d_in;
        i_hit = d_wr & i_in & (i_idx == d_idx);
    end

    // Post-write view of the data word, used for write-first fetches.
    always_comb begin
        wmerge = mem[d_idx];
        for (int k = 0; k < NB; k++) begin
            if (dbe[k]) begin
                wmerge[8*k +: 8] = din[8*k +: 8];
            end
        end
    end

    // Clear-pass sequencing and ready generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        init_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
        endcase
    end

    // Response next-state: strobes for accepted requests, data or zero.
    always_comb begin
        ivalid_d = i_acc;
        ierr_d   = i_acc & ~i_in;
        iout_d   = '0;
        if (i_acc && i_in) begin
            iout_d = i_hit ? wmerge : mem[i_idx];
        end
        dvalid_d = d_acc;
        derr_d   = d_acc & ~d_in;
        dout_d   = '0;
        if (d_acc && !drw && d_in) begin
            dout_d = mem[d_idx];
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR_INIT ? ST_INIT : ST_RUN;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            ivalid_q <= 1'b0;
            ierr_q   <= 1'b0;
            iout_q   <= '0;
            dvalid_q <= 1'b0;
            derr_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            ivalid_q <= ivalid_d;
            ierr_q   <= ierr_d;
            iout_q   <= iout_d;
            dvalid_q <= dvalid_d;
            derr_q   <= derr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage: clear pass or byte-lane data writes; never reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt_q] <= '0;
        end else if (d_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (dbe[k]) begin
                    mem[d_idx][8*k +: 8] <= din[8*k +: 8];
                end
            end
        end
    end

    assign ready  = ready_q;
    assign iout   = iout_q;
    assign ivalid = ivalid_q;
    assign ierr   = ierr_q;
    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign derr   = derr_q;

endmodule

// File: tb/tb_mod_ram_ctrl.sv
// Bench for mod_ram_ctrl: directed scenarios plus random traffic checked
// against a word-array model of the RAM (16 words, 32 bit, base 0).
module tb_mod_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready;
    logic        ie = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iout;
    logic        ivalid, ierr;
    logic        de = 1'b0;
    logic        drw = 1'b0;
    logic [3:0]  dbe = '0;
    logic [31:0] daddr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        dvalid, derr;

    int npass = 0;
    int ntotal = 0;

    logic [31:0] model [16];

    always #5 clk = ~clk;

    mod_ram_ctrl #(
        .DATA_W(32), .DEPTH_LOG2(4), .ADDR_W(32),
        .BASE_ADDR(32'h0), .CLEAR_INIT(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .ie(ie), .iaddr(iaddr), .iout(iout),
        .ivalid(ivalid), .ierr(ierr),
        .de(de), .drw(drw), .dbe(dbe), .daddr(daddr),
        .din(din), .dout(dout), .dvalid(dvalid), .derr(derr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_in();
        ie = 0; de = 0; drw = 0; dbe = 0;
        iaddr = 0; daddr = 0; din = 0;
    endtask

    // One request cycle in RUN: drive, predict, clock, compare.
    task automatic step(input string tag,
                        input logic i_e, input logic [31:0] ia,
                        input logic d_e, input logic d_rw,
                        input logic [3:0] be, input logic [31:0] da,
                        input logic [31:0] wd);
        logic ir, dr;
        logic [31:0] e_io, e_do;
        ie = i_e; iaddr = ia; de = d_e; drw = d_rw;
        dbe = be; daddr = da; din = wd;
        ir = ia < 32'd64;
        dr = da < 32'd64;
        if (d_e && d_rw && dr)
            for (int k = 0; k < 4; k++)
                if (be[k]) model[da[5:2]][8*k +: 8] = wd[8*k +: 8];
        e_io = (i_e && ir) ? model[ia[5:2]] : 32'h0;
        e_do = (d_e && !d_rw && dr) ? model[da[5:2]] : 32'h0;
        @(posedge clk);
        #1;
        chk({tag, ".ivalid"}, 32'(ivalid), 32'(i_e));
        chk({tag, ".ierr"}, 32'(ierr), 32'(i_e && !ir));
        chk({tag, ".iout"}, iout, e_io);
        chk({tag, ".dvalid"}, 32'(dvalid), 32'(d_e));
        chk({tag, ".derr"}, 32'(derr), 32'(d_e && !dr));
        chk({tag, ".dout"}, dout, e_do);
        @(negedge clk);
    endtask

    // Clear pass: 16 cycles of ready=0 with requests ignored, then ready=1.
    task automatic run_init(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, ".ready_lo"}, 32'(ready), 32'h0);
            chk({tag, ".no_strobe"}, 32'({ivalid, dvalid}), 32'h0);
            ie = 1; de = 1; drw = 1; dbe = 4'hF;
            iaddr = 32'(4 * i); daddr = 32'(4 * i); din = $urandom;
            @(negedge clk);
        end
        idle_in();
        chk({tag, ".ready_hi"}, 32'(ready), 32'h1);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) return 32'($urandom_range(64, 127));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [31:0] a, b;
        idle_in();
        #1;
        chk("rst.ready", 32'(ready), 32'h0);
        chk("rst.strobes", 32'({ivalid, ierr, dvalid, derr}), 32'h0);
        chk("rst.iout", iout, 32'h0);
        chk("rst.dout", dout, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_init("T1");

        for (int i = 0; i < 16; i++)
            step("T1.rd", 0, 0, 1, 0, 4'h0, 32'(4 * i), 0);

        step("T2.wr", 0, 0, 1, 1, 4'hF, 32'h8, 32'hDEADBEEF);
        step("T2.rd", 0, 0, 1, 0, 4'h0, 32'h8, 0);
        chk("T2.value", dout, 32'hDEADBEEF);
        step("T2.idle", 0, 0, 0, 0, 4'h0, 0, 0);
        chk("T2.after", dout, 32'h0);

        step("T3.wr", 0, 0, 1, 1, 4'b0101, 32'h8, 32'h11223344);
        step("T3.rd", 0, 0, 1, 0, 4'h0, 32'hB, 0);
        chk("T3.value", dout, 32'hDE22BE44);

        step("T4.col", 1, 32'h10, 1, 1, 4'hF, 32'h10, 32'hCAFEF00D);
        chk("T4.iout", iout, 32'hCAFEF00D);
        step("T4.colp", 1, 32'h8, 1, 1, 4'b1000, 32'h9, 32'h55000000);
        chk("T4.partial", iout, 32'h5522BE44);

        step("T5.w0", 0, 0, 1, 1, 4'hF, 32'h0, 32'h01020304);
        step("T5.woor", 0, 0, 1, 1, 4'hF, 32'h40, 32'hFFFFFFFF);
        chk("T5.derr", 32'(derr), 32'h1);
        step("T5.ioor", 1, 32'h44, 1, 0, 4'h0, 32'h0, 0);
        chk("T5.ierr", 32'({ivalid, ierr}), 32'h3);
        chk("T5.word0", dout, 32'h01020304);
        step("T5.top", 1, 32'h3F, 1, 0, 4'h0, 32'hFFFFFFFC, 0);
        step("T5.be0", 0, 0, 1, 1, 4'h0, 32'h0, 32'hAAAAAAAA);
        step("T5.be0rd", 1, 32'h0, 0, 0, 4'h0, 0, 0);
        chk("T5.be0val", iout, 32'h01020304);

        for (int n = 0; n < 300; n++) begin
            a = rand_addr();
            b = ($urandom_range(0, 3) == 0) ? a : rand_addr();
            step("RND", 1'($urandom), b, 1'($urandom), 1'($urandom),
                 4'($urandom), a, $urandom);
        end

        step("T6.rd", 1, 32'h8, 1, 0, 4'h0, 32'h10, 0);
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("T6.async", 32'({ready, ivalid, ierr, dvalid, derr}), 32'h0);
        chk("T6.buses", iout | dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("T6.mid", 32'({ready, ivalid, dvalid}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init("T6");
        step("T6.clr", 1, 32'h10, 1, 0, 4'h0, 32'h8, 0);
        chk("T6.cleared", iout | dout, 32'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
